// File: rtl/mux_arb_reg.sv
// mux_arb_reg: registered N-channel mux with fixed-select or round-robin arbitration and valid/ready handshakes
module mux_arb_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_nreset,
  input  logic                   i_mode,
  input  logic [SELW-1:0]        i_sel,
  input  logic [NCH-1:0]         i_in_valid,
  input  logic [NCH*WIDTH-1:0]   i_in_data,
  output logic [NCH-1:0]         o_in_ready,
  output logic                   o_out_valid,
  output logic [WIDTH-1:0]       o_out_data,
  output logic [SELW-1:0]        o_out_ch,
  input  logic                   i_out_ready
);
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic [SELW-1:0]  r_ptr;
  logic             w_space;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt;
  logic [WIDTH-1:0] w_data;
  logic             w_acc;
  assign w_space = !r_out_valid || i_out_ready;
  assign w_acc   = w_gnt_vld && w_space && i_nreset;
  // grant: fixed sel in mode 0; in mode 1 the lowest valid channel at or above ptr wins, else the lowest below it
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (i_mode && i_in_valid[k] && SELW'(k) < r_ptr) begin
        w_gnt_vld = 1'b1;
        w_gnt     = SELW'(k);
      end
    for (int k = NCH - 1; k >= 0; k--)
      if (i_mode && i_in_valid[k] && SELW'(k) >= r_ptr) begin
        w_gnt_vld = 1'b1;
        w_gnt     = SELW'(k);
      end
    for (int k = 0; k < NCH; k++)
      if (!i_mode && i_in_valid[k] && SELW'(k) == i_sel) begin
        w_gnt_vld = 1'b1;
        w_gnt     = SELW'(k);
      end
  end
  // one-hot ready and data select for the granted channel
  always_comb begin
    o_in_ready = '0;
    w_data     = '0;
    for (int k = 0; k < NCH; k++) begin
      o_in_ready[k] = w_acc && w_gnt == SELW'(k);
      w_data        = w_gnt == SELW'(k) ? i_in_data[k*WIDTH +: WIDTH] : w_data;
    end
  end
  // output register: load on accept, empty on drain, hold on stall
  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_ch    <= w_gnt;
      r_ptr       <= w_gnt == SELW'(NCH - 1) ? '0 : w_gnt + 1'b1;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_ch    = r_out_ch;
endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg: directed vectors with a behavioural model checked every cycle
module tb_mux_arb_reg;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 3;
  logic                 clk = 1'b0;
  logic                 nreset;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_ready;
  int vectors = 0;
  int miscompares = 0;
  logic             m_en = 1'b0;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_ch;
  int               m_ptr;
  mux_arb_reg #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .i_clk(clk), .i_nreset(nreset), .i_mode(mode), .i_sel(sel),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_out_ch(out_ch),
    .i_out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int grant();
    if (!mode) begin
      for (int i = 0; i < NCH; i++)
        if (i == int'(sel) && in_valid[i]) return i;
      return -1;
    end
    for (int off = 0; off < NCH; off++)
      if (in_valid[(m_ptr + off) % NCH]) return (m_ptr + off) % NCH;
    return -1;
  endfunction
  always @(posedge clk) begin
    if (!nreset) begin
      m_en    <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= 0;
      m_ptr   <= 0;
    end else if (grant() >= 0 && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_data  <= in_data[grant()*WIDTH +: WIDTH];
      m_ch    <= grant();
      m_ptr   <= (grant() + 1) % NCH;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end
  always @(negedge clk) begin
    if (m_en) begin
      check("model_ready", 32'(in_ready),
            (nreset && (!m_valid || out_ready) && grant() >= 0) ? 32'(1 << grant()) : 32'd0);
      check("model_valid", 32'(out_valid), 32'(m_valid));
      check("model_data", 32'(out_data), 32'(m_data));
      check("model_ch", 32'(out_ch), 32'(m_ch));
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    nreset = 1'b0; mode = 1'b1; sel = '0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {8'h44, 8'hA5, 8'h3C, 8'h11};
    cyc(); cyc();
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ch", 32'(out_ch), 0);
    check("rst_ready", 32'(in_ready), 32'b0000);
    cyc(); nreset = 1'b1;
    @(negedge clk);
    check("first_ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 7) in_valid = 4'b1010;
      @(negedge clk);
      check("rr_ch", 32'(out_ch), 32'(k % 4));
      check("rr_valid", 32'(out_valid), 1);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      check("alt_ch", 32'(out_ch), (k % 2 == 0) ? 32'd1 : 32'd3);
    end
    cyc(); mode = 1'b0; sel = 3'd2; in_valid = 4'b1111;
    @(negedge clk);
    check("fix_ready", 32'(in_ready), 32'b0100);
    cyc(); sel = 3'd5;
    @(negedge clk);
    check("fix_data", 32'(out_data), 32'hA5);
    check("fix_ch", 32'(out_ch), 2);
    check("sel5_ready", 32'(in_ready), 0);
    cyc();
    @(negedge clk);
    check("drain_valid", 32'(out_valid), 0);
    check("drain_data", 32'(out_data), 32'hA5);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      check("sel5_idle", 32'(in_ready), 0);
    end
    cyc(); sel = 3'd1; out_ready = 1'b0;
    @(negedge clk);
    check("bp_load_ready", 32'(in_ready), 32'b0010);
    for (int k = 0; k < 5; k++) begin
      cyc(); mode = k[0]; sel = SELW'(k);
      @(negedge clk);
      check("bp_data", 32'(out_data), 32'h3C);
      check("bp_ch", 32'(out_ch), 1);
      check("bp_ready", 32'(in_ready), 0);
    end
    cyc(); out_ready = 1'b1; mode = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'b0100);
    cyc(); out_ready = 1'b0;
    @(negedge clk);
    check("bp_next_ch", 32'(out_ch), 2);
    check("bp_next_data", 32'(out_data), 32'hA5);
    cyc(); nreset = 1'b0;
    @(negedge clk);
    check("mid_hold_ch", 32'(out_ch), 2);
    check("mid_rst_ready", 32'(in_ready), 0);
    cyc(); nreset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_ready2", 32'(in_ready), 32'b0001);
    cyc(); in_valid = 4'b0110;
    @(negedge clk);
    check("mid_first_ch", 32'(out_ch), 0);
    check("mid_first_data", 32'(out_data), 32'h11);
    cyc(); in_valid = 4'b1001;
    @(negedge clk);
    check("tail_ch1", 32'(out_ch), 1);
    cyc(); in_valid = 4'b0000;
    @(negedge clk);
    check("tail_ch3", 32'(out_ch), 3);
    cyc();
    @(negedge clk);
    check("tail_drain", 32'(out_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
